// File: rtl/puf_resp_accum_pkg.sv
// Shared definitions for the PUF response accumulator: FSM encodings,
// response word width and the default evaluation timeout.
package puf_resp_accum_pkg;

    localparam int RESP_W          = 32;
    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/puf_resp_accum_if.sv
// Bundle of the PUF request/response, adder operand and result handshake
// signals; slave is the accumulator side, master the surrounding system.
interface puf_resp_accum_if #(
    parameter int NSAMP_W = 16
);
    import puf_resp_accum_pkg::*;

    logic                start;
    logic [NSAMP_W-1:0]  num_samples;
    logic                eval_req;
    logic                resp_valid;
    logic                resp_bit;
    logic [RESP_W-1:0]   add_a;
    logic [RESP_W-1:0]   add_b;
    logic [RESP_W-1:0]   add_c;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [RESP_W-1:0]   out_count;
    logic                out_majority;
    logic                out_timeout;

    modport slave (
        input  start, num_samples, resp_valid, resp_bit, add_c, out_ready,
        output eval_req, add_a, add_b, busy, out_valid, out_count,
               out_majority, out_timeout
    );

    modport master (
        output start, num_samples, resp_valid, resp_bit, add_c, out_ready,
        input  eval_req, add_a, add_b, busy, out_valid, out_count,
               out_majority, out_timeout
    );

endinterface

// File: rtl/adder_32.sv
// Plain 32-bit combinational adder that closes the accumulation loop
// outside the accumulator.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a + b;
endmodule

// File: rtl/puf_resp_accum.sv
// Issues one PUF evaluation per sample and counts '1' responses through an
// external adder, then hands count/majority/timeout out via valid/ready.
module puf_resp_accum
    import puf_resp_accum_pkg::*;
#(
    parameter int NSAMP_W     = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TMR_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    puf_resp_accum_if.slave  bus
);

    state_t             state, state_nxt;
    logic [RESP_W-1:0]  acc;
    logic [NSAMP_W-1:0] ctr, ctr_inc, n_lat;
    logic [TMR_W-1:0]   timer;
    logic               tflag;
    logic               timer_exp;
    logic [RESP_W:0]    acc_x2;
    logic [RESP_W:0]    n_ext;

    assign ctr_inc   = ctr + NSAMP_W'(1);
    assign timer_exp = (timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A response arriving on the expiry cycle is checked first, so it wins over timeout.
    always_comb begin
        state_nxt     = state;
        bus.eval_req  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nxt = (bus.num_samples == '0) ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                bus.eval_req = 1'b1;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.resp_valid)
                    state_nxt = (ctr_inc == n_lat) ? ST_DONE : ST_REQ;
                else if (timer_exp)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            ctr   <= '0;
            timer <= '0;
            n_lat <= '0;
            tflag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        n_lat <= bus.num_samples;
                        acc   <= '0;
                        ctr   <= '0;
                        tflag <= 1'b0;
                    end
                end
                ST_REQ: timer <= '0;
                ST_WAIT: begin
                    if (bus.resp_valid) begin
                        acc <= bus.add_c;
                        ctr <= ctr_inc;
                    end else begin
                        timer <= timer + TMR_W'(1);
                        if (timer_exp) tflag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Majority compare is done one bit wider so doubling the count cannot wrap.
    assign acc_x2 = {acc, 1'b0};
    assign n_ext  = {{(RESP_W + 1 - NSAMP_W){1'b0}}, n_lat};

    assign bus.busy         = (state != ST_IDLE);
    assign bus.add_a        = acc;
    assign bus.add_b        = {{(RESP_W-1){1'b0}}, bus.resp_bit};
    assign bus.out_count    = acc;
    assign bus.out_majority = (state == ST_DONE) && (acc_x2 > n_ext);
    assign bus.out_timeout  = (state == ST_DONE) && tflag;

endmodule

// File: tb/tb_puf_resp_accum.sv
// Directed bench for puf_resp_accum with an external adder_32; a linear
// sequence of runs with hand-computed expected results.
module tb_puf_resp_accum;
    import puf_resp_accum_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   eval_count = 0;

    always #5 clk = ~clk;

    puf_resp_accum_if #(.NSAMP_W(16)) bus ();

    puf_resp_accum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    adder_32 u_adder (
        .a (bus.add_a),
        .b (bus.add_b),
        .y (bus.add_c)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.eval_req === 1'b1) eval_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a run of n samples and answer the first nresp requests right away.
    task automatic applyStimulus(input int n, input logic [7:0] bits, input int nresp);
        eval_count      = 0;
        bus.num_samples = 16'(n);
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < nresp; i++) begin
            tick();
            bus.resp_valid = 1'b1;
            bus.resp_bit   = bits[i];
            tick();
            bus.resp_valid = 1'b0;
            bus.resp_bit   = 1'b0;
        end
    endtask

    task automatic finishRun();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.resp_valid  = 1'b0;
        bus.resp_bit    = 1'b0;
        bus.out_ready   = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_eval_req", bus.eval_req, 0);
        checkOutput("rst_add_a", bus.add_a, 0);
        checkOutput("rst_count", bus.out_count, 0);
        checkOutput("rst_majority", bus.out_majority, 0);
        checkOutput("rst_timeout", bus.out_timeout, 0);

        tick();
        rst_n        = 1'b1;
        bus.resp_bit = 1'b1;
        @(negedge clk);
        checkOutput("add_b_one", bus.add_b, 1);
        bus.resp_bit = 1'b0;
        #1;
        checkOutput("add_b_zero", bus.add_b, 0);
        checkOutput("idle_add_a", bus.add_a, 0);

        // n=8, responses 1,0,1,1,0,1,1,1
        tick();
        applyStimulus(8, 8'b1110_1101, 8);
        @(negedge clk);
        checkOutput("n8_latency17", bus.out_valid, 1);
        checkOutput("n8_evals", eval_count, 8);
        checkOutput("n8_count", bus.out_count, 6);
        checkOutput("n8_majority", bus.out_majority, 1);
        checkOutput("n8_timeout", bus.out_timeout, 0);

        // hold DONE with out_ready low; start and stray responses must be ignored
        tick();
        bus.start      = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_bit   = 1'b1;
        repeat (10) tick();
        bus.start      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_bit   = 1'b0;
        @(negedge clk);
        checkOutput("hold_valid", bus.out_valid, 1);
        checkOutput("hold_count", bus.out_count, 6);
        checkOutput("hold_majority", bus.out_majority, 1);
        checkOutput("hold_evals", eval_count, 8);

        tick();
        bus.out_ready   = 1'b1;
        bus.start       = 1'b1;
        bus.num_samples = 16'd4;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        @(negedge clk);
        checkOutput("exit_busy", bus.busy, 0);
        checkOutput("exit_valid", bus.out_valid, 0);
        checkOutput("exit_majority_gated", bus.out_majority, 0);

        tick();
        bus.resp_valid = 1'b1;
        bus.resp_bit   = 1'b1;
        tick();
        tick();
        bus.resp_valid = 1'b0;
        bus.resp_bit   = 1'b0;
        @(negedge clk);
        checkOutput("idle_stray_acc", bus.add_a, 6);
        checkOutput("idle_stray_busy", bus.busy, 0);

        // n=4, responses 1,1,0,0: tie is not a majority
        tick();
        applyStimulus(4, 8'b0000_0011, 4);
        @(negedge clk);
        checkOutput("n4_valid", bus.out_valid, 1);
        checkOutput("n4_count", bus.out_count, 2);
        checkOutput("n4_majority", bus.out_majority, 0);
        finishRun();

        // n=0: straight to DONE without any evaluation
        tick();
        applyStimulus(0, 8'b0, 0);
        @(negedge clk);
        checkOutput("n0_valid", bus.out_valid, 1);
        checkOutput("n0_count", bus.out_count, 0);
        checkOutput("n0_majority", bus.out_majority, 0);
        checkOutput("n0_evals", eval_count, 0);
        finishRun();

        // n=5, PUF goes silent after two ones
        tick();
        applyStimulus(5, 8'b0000_0011, 2);
        repeat (1024) tick();
        @(negedge clk);
        checkOutput("to_not_yet", bus.out_valid, 0);
        tick();
        @(negedge clk);
        checkOutput("to_valid", bus.out_valid, 1);
        checkOutput("to_flag", bus.out_timeout, 1);
        checkOutput("to_count", bus.out_count, 2);
        checkOutput("to_majority", bus.out_majority, 0);
        checkOutput("to_evals", eval_count, 3);
        finishRun();

        // n=1, response lands exactly on the expiry cycle
        tick();
        applyStimulus(1, 8'b0, 0);
        tick();
        repeat (1023) tick();
        @(negedge clk);
        checkOutput("edge_not_yet", bus.out_valid, 0);
        bus.resp_valid = 1'b1;
        bus.resp_bit   = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        bus.resp_bit   = 1'b0;
        @(negedge clk);
        checkOutput("edge_valid", bus.out_valid, 1);
        checkOutput("edge_timeout", bus.out_timeout, 0);
        checkOutput("edge_count", bus.out_count, 1);
        checkOutput("edge_majority", bus.out_majority, 1);
        finishRun();

        // reset while waiting for a response discards the run
        tick();
        applyStimulus(3, 8'b0, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_valid", bus.out_valid, 0);
        checkOutput("midrst_add_a", bus.add_a, 0);
        repeat (5) tick();
        @(negedge clk);
        checkOutput("midrst_no_result", bus.out_valid, 0);
        checkOutput("midrst_evals", eval_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
